// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and helpers for the memory bus arbiter.
// Covers FSM states, port owner encoding and the round-robin pick.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_RDATA = 2'd2,
        ST_WDATA = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_ICACHE = 1'b0,
        OWN_DCACHE = 1'b1
    } arb_owner_t;

    // Dcache wins when alone, or on a tie when icache was served last.
    function automatic logic pick_dcache(
        input logic       ireq,
        input logic       dreq,
        input arb_owner_t rr_last
    );
        return dreq && (!ireq || rr_last == OWN_ICACHE);
    endfunction

endpackage

// File: rtl/mem_arb_beat_cnt.sv
// Beat counter for one burst: clear, enable and last-beat flag.
// Wraps to zero naturally because BURST_LEN is a power of two.
module mem_arb_beat_cnt #(
    parameter int BURST_LEN = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         clr,
    output logic [$clog2(BURST_LEN)-1:0] cnt,
    output logic                         last
);

    localparam int CW = $clog2(BURST_LEN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign last = (cnt == CW'(BURST_LEN - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one burst memory port between icache and dcache.
// One transaction in flight; grant and data paths are combinational off state.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_req_i,
    input  logic [ADDR_W-1:0] icache_addr_i,
    output logic              icache_gnt_o,
    output logic              icache_rvalid_o,
    output logic [DATA_W-1:0] icache_rdata_o,
    output logic              icache_done_o,
    input  logic              dcache_req_i,
    input  logic              dcache_we_i,
    input  logic [ADDR_W-1:0] dcache_addr_i,
    output logic              dcache_gnt_o,
    output logic              dcache_rvalid_o,
    output logic [DATA_W-1:0] dcache_rdata_o,
    input  logic [DATA_W-1:0] dcache_wdata_i,
    output logic              dcache_wready_o,
    output logic              dcache_done_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    output logic              mem_wvalid_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_wready_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int CW = $clog2(BURST_LEN);

    arb_state_t        state;
    arb_owner_t        owner;
    arb_owner_t        rr_last;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [CW-1:0]     beat_cnt;
    logic              last_beat;

    logic req_any;
    logic pick_d;
    logic rd_beat;
    logic wr_beat;

    assign req_any = icache_req_i || dcache_req_i;
    assign pick_d  = pick_dcache(icache_req_i, dcache_req_i, rr_last);
    assign rd_beat = (state == ST_RDATA) && mem_rvalid_i;
    assign wr_beat = (state == ST_WDATA) && mem_wready_i;

    mem_arb_beat_cnt #(
        .BURST_LEN(BURST_LEN)
    ) u_beat_cnt (
        .clk (clk),
        .rst (rst),
        .en  (rd_beat || wr_beat),
        .clr ((state == ST_ADDR) && mem_gnt_i),
        .cnt (beat_cnt),
        .last(last_beat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            owner   <= OWN_ICACHE;
            rr_last <= OWN_ICACHE;
            addr_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_any) begin
                        owner   <= pick_d ? OWN_DCACHE : OWN_ICACHE;
                        rr_last <= pick_d ? OWN_DCACHE : OWN_ICACHE;
                        addr_q  <= pick_d ? dcache_addr_i : icache_addr_i;
                        we_q    <= pick_d && dcache_we_i;
                        state   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (mem_gnt_i) state <= we_q ? ST_WDATA : ST_RDATA;
                end
                ST_RDATA: begin
                    if (rd_beat && last_beat) state <= ST_IDLE;
                end
                ST_WDATA: begin
                    if (wr_beat && last_beat) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Everything is forced low while reset is held, including the grants.
    always_comb begin
        icache_gnt_o    = 1'b0;
        icache_rvalid_o = 1'b0;
        icache_rdata_o  = '0;
        icache_done_o   = 1'b0;
        dcache_gnt_o    = 1'b0;
        dcache_rvalid_o = 1'b0;
        dcache_rdata_o  = '0;
        dcache_wready_o = 1'b0;
        dcache_done_o   = 1'b0;
        mem_req_o       = 1'b0;
        mem_we_o        = 1'b0;
        mem_addr_o      = '0;
        mem_wvalid_o    = 1'b0;
        mem_wdata_o     = '0;
        if (rst) begin
            icache_rdata_o = mem_rdata_i;
            dcache_rdata_o = mem_rdata_i;
            unique case (state)
                ST_IDLE: begin
                    icache_gnt_o = req_any && !pick_d;
                    dcache_gnt_o = req_any && pick_d;
                end
                ST_ADDR: begin
                    mem_req_o  = 1'b1;
                    mem_we_o   = we_q;
                    mem_addr_o = addr_q;
                end
                ST_RDATA: begin
                    if (owner == OWN_DCACHE) begin
                        dcache_rvalid_o = mem_rvalid_i;
                        dcache_done_o   = rd_beat && last_beat;
                    end else begin
                        icache_rvalid_o = mem_rvalid_i;
                        icache_done_o   = rd_beat && last_beat;
                    end
                end
                ST_WDATA: begin
                    mem_wvalid_o    = 1'b1;
                    mem_wdata_o     = dcache_wdata_i;
                    dcache_wready_o = mem_wready_i;
                    dcache_done_o   = wr_beat && last_beat;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: vector table plus multi-cycle sequences.
module tb_mem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int BL = 4;
    localparam int NV = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic          icache_req, icache_gnt, icache_rvalid, icache_done;
    logic [AW-1:0] icache_addr;
    logic [DW-1:0] icache_rdata;
    logic          dcache_req, dcache_we, dcache_gnt, dcache_rvalid;
    logic          dcache_wready, dcache_done;
    logic [AW-1:0] dcache_addr;
    logic [DW-1:0] dcache_rdata, dcache_wdata;
    logic          mem_req, mem_we, mem_gnt, mem_wvalid, mem_wready, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .icache_req_i   (icache_req),
        .icache_addr_i  (icache_addr),
        .icache_gnt_o   (icache_gnt),
        .icache_rvalid_o(icache_rvalid),
        .icache_rdata_o (icache_rdata),
        .icache_done_o  (icache_done),
        .dcache_req_i   (dcache_req),
        .dcache_we_i    (dcache_we),
        .dcache_addr_i  (dcache_addr),
        .dcache_gnt_o   (dcache_gnt),
        .dcache_rvalid_o(dcache_rvalid),
        .dcache_rdata_o (dcache_rdata),
        .dcache_wdata_i (dcache_wdata),
        .dcache_wready_o(dcache_wready),
        .dcache_done_o  (dcache_done),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_gnt_i      (mem_gnt),
        .mem_wvalid_o   (mem_wvalid),
        .mem_wdata_o    (mem_wdata),
        .mem_wready_i   (mem_wready),
        .mem_rvalid_i   (mem_rvalid),
        .mem_rdata_i    (mem_rdata)
    );

    typedef struct {
        logic          ireq;
        logic [AW-1:0] iaddr;
        logic          dreq;
        logic          dwe;
        logic [AW-1:0] daddr;
        logic [DW-1:0] dwdata;
        logic          mgnt;
        logic          mrv;
        logic [DW-1:0] mrdata;
        logic          mwr;
        logic [9:0]    ctrl;
        logic [AW-1:0] maddr;
        logic [DW-1:0] wdata;
    } vec_t;

    vec_t vecs [NV];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {igt,irv,idn,dgt,drv,dwr,ddn,mreq,mwe,mwv}
    function automatic logic [9:0] ctrl();
        return {icache_gnt, icache_rvalid, icache_done, dcache_gnt,
                dcache_rvalid, dcache_wready, dcache_done,
                mem_req, mem_we, mem_wvalid};
    endfunction

    function automatic logic any_out();
        return |{icache_gnt, icache_rvalid, icache_rdata, icache_done,
                 dcache_gnt, dcache_rvalid, dcache_rdata, dcache_wready,
                 dcache_done, mem_req, mem_we, mem_addr, mem_wvalid,
                 mem_wdata};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_in();
        icache_req   = 1'b0;
        icache_addr  = '0;
        dcache_req   = 1'b0;
        dcache_we    = 1'b0;
        dcache_addr  = '0;
        dcache_wdata = '0;
        mem_gnt      = 1'b0;
        mem_rvalid   = 1'b0;
        mem_rdata    = '0;
        mem_wready   = 1'b0;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        // Test 1 (icache read) followed by test 3 (dcache writeback)
        vecs[0]  = '{1'b1, 32'h8000_0040, 1'b0, 1'b0, 32'h0, 64'h0,
                     1'b0, 1'b0, 64'h0, 1'b0, 10'b1000000000, 32'h0, 64'h0};
        vecs[1]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 64'h0,
                     1'b0, 1'b0, 64'h0, 1'b0, 10'b0000000100, 32'h8000_0040, 64'h0};
        vecs[2]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 64'h0,
                     1'b0, 1'b0, 64'h0, 1'b0, 10'b0000000100, 32'h8000_0040, 64'h0};
        vecs[3]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 64'h0,
                     1'b1, 1'b0, 64'h0, 1'b0, 10'b0000000100, 32'h8000_0040, 64'h0};
        vecs[4]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 64'h0,
                     1'b0, 1'b1, 64'h11, 1'b0, 10'b0100000000, 32'h0, 64'h0};
        vecs[5]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 64'h0,
                     1'b0, 1'b1, 64'h22, 1'b0, 10'b0100000000, 32'h0, 64'h0};
        vecs[6]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 64'h0,
                     1'b0, 1'b0, 64'h0, 1'b0, 10'b0000000000, 32'h0, 64'h0};
        vecs[7]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 64'h0,
                     1'b0, 1'b1, 64'h33, 1'b0, 10'b0100000000, 32'h0, 64'h0};
        vecs[8]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 64'h0,
                     1'b0, 1'b1, 64'h44, 1'b0, 10'b0110000000, 32'h0, 64'h0};
        vecs[9]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 64'h0,
                     1'b0, 1'b1, 64'h55, 1'b0, 10'b0000000000, 32'h0, 64'h0};
        vecs[10] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_1000, 64'hA,
                     1'b0, 1'b0, 64'h0, 1'b0, 10'b0001000000, 32'h0, 64'h0};
        vecs[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 64'hA,
                     1'b1, 1'b0, 64'h0, 1'b0, 10'b0000000110, 32'h8000_1000, 64'h0};
        vecs[12] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 64'hA,
                     1'b0, 1'b0, 64'h0, 1'b1, 10'b0000010001, 32'h0, 64'hA};
        vecs[13] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 64'hB,
                     1'b0, 1'b0, 64'h0, 1'b0, 10'b0000000001, 32'h0, 64'hB};
        vecs[14] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 64'hB,
                     1'b0, 1'b0, 64'h0, 1'b1, 10'b0000010001, 32'h0, 64'hB};
        vecs[15] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 64'hC,
                     1'b0, 1'b0, 64'h0, 1'b1, 10'b0000010001, 32'h0, 64'hC};
        vecs[16] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 64'hD,
                     1'b0, 1'b0, 64'h0, 1'b1, 10'b0000011001, 32'h0, 64'hD};
        vecs[17] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 64'hD,
                     1'b0, 1'b1, 64'h0, 1'b1, 10'b0000000000, 32'h0, 64'h0};

        // Reset state: outputs low even with every input active
        clear_in();
        rst        = 1'b0;
        icache_req = 1'b1;
        dcache_req = 1'b1;
        mem_rvalid = 1'b1;
        mem_wready = 1'b1;
        mem_gnt    = 1'b1;
        mem_rdata  = 64'hFFFF_0000_FFFF_0000;
        #1;
        chk("reset outputs", 64'(any_out()), 64'd0);
        chk("reset state", 64'(dut.state), 64'd0);
        chk("reset beat_cnt", 64'(dut.beat_cnt), 64'd0);
        do_reset();

        for (int i = 0; i < NV; i++) begin
            icache_req   = vecs[i].ireq;
            icache_addr  = vecs[i].iaddr;
            dcache_req   = vecs[i].dreq;
            dcache_we    = vecs[i].dwe;
            dcache_addr  = vecs[i].daddr;
            dcache_wdata = vecs[i].dwdata;
            mem_gnt      = vecs[i].mgnt;
            mem_rvalid   = vecs[i].mrv;
            mem_rdata    = vecs[i].mrdata;
            mem_wready   = vecs[i].mwr;
            #1;
            chk($sformatf("v%0d ctrl", i), 64'(ctrl()), 64'(vecs[i].ctrl));
            if (vecs[i].ctrl[2])
                chk($sformatf("v%0d addr", i), 64'(mem_addr), 64'(vecs[i].maddr));
            if (vecs[i].ctrl[0])
                chk($sformatf("v%0d wdata", i), 64'(mem_wdata), 64'(vecs[i].wdata));
            if (vecs[i].ctrl[8])
                chk($sformatf("v%0d rdata", i), 64'(icache_rdata), 64'(vecs[i].mrdata));
            tick();
        end
        chk("beat_cnt after bursts", 64'(dut.beat_cnt), 64'd0);

        // Both requesters held: D,I,D,I,D,I with grant in the IDLE after done
        do_reset();
        icache_req  = 1'b1;
        icache_addr = 32'h8000_0100;
        dcache_req  = 1'b1;
        dcache_addr = 32'h8000_2200;
        for (int t = 0; t < 6; t++) begin
            logic exp_d;
            exp_d = (t % 2 == 0);
            #1;
            chk($sformatf("rr%0d gnt", t), 64'({icache_gnt, dcache_gnt}),
                64'(exp_d ? 2'b01 : 2'b10));
            tick();
            mem_gnt = 1'b1;
            #1;
            chk($sformatf("rr%0d addr", t), 64'(mem_addr),
                64'(exp_d ? 32'h8000_2200 : 32'h8000_0100));
            tick();
            mem_gnt = 1'b0;
            for (int b = 0; b < BL; b++) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 64'(t * 16 + b);
                #1;
                chk($sformatf("rr%0d b%0d rv", t, b),
                    64'({icache_rvalid, dcache_rvalid}),
                    64'(exp_d ? 2'b01 : 2'b10));
                chk($sformatf("rr%0d b%0d done", t, b),
                    64'({icache_done, dcache_done}),
                    64'((b == BL - 1) ? (exp_d ? 2'b01 : 2'b10) : 2'b00));
                tick();
            end
            mem_rvalid = 1'b0;
        end
        clear_in();

        // Stray rvalid in ADDR, then reset after two beats
        do_reset();
        icache_req  = 1'b1;
        icache_addr = 32'h8000_0080;
        #1;
        chk("ab gnt", 64'(icache_gnt), 64'd1);
        tick();
        icache_req = 1'b0;
        mem_rvalid = 1'b1;
        #1;
        chk("stray addr rv", 64'({icache_rvalid, icache_done,
                                  dcache_rvalid, dcache_done}), 64'd0);
        chk("stray addr cnt", 64'(dut.beat_cnt), 64'd0);
        tick();
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b1;
        tick();
        mem_gnt = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 64'(b + 1);
            tick();
        end
        #1;
        chk("pre-abort rv", 64'(icache_rvalid), 64'd1);
        rst = 1'b0;
        #1;
        chk("abort outputs", 64'(any_out()), 64'd0);
        tick();
        rst        = 1'b1;
        mem_rvalid = 1'b0;
        icache_req = 1'b1;
        #1;
        chk("restart gnt", 64'(icache_gnt), 64'd1);
        tick();
        icache_req = 1'b0;
        mem_gnt    = 1'b1;
        #1;
        chk("restart addr", 64'(mem_addr), 64'h8000_0080);
        tick();
        mem_gnt = 1'b0;
        for (int b = 0; b < BL; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 64'(b + 16);
            #1;
            chk($sformatf("restart b%0d", b), 64'({icache_rvalid, icache_done}),
                64'((b == BL - 1) ? 2'b11 : 2'b10));
            tick();
        end
        clear_in();
        #1;
        chk("restart idle", 64'(dut.state), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
